// File: rtl/data_mem_responder.sv
// Memory-side responder for the TessiaX32 data port: one request at a time, fixed-latency access, held response.
// Optional misaligned-access error reporting is enabled with the DATA_MEM_ALIGN_CHECK_EN macro.
`timescale 1ns/1ps

module data_mem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int WORDS   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } stateT;

    stateT             state;
    logic [CNT_W-1:0]  cnt;
    logic              capWe;
    logic [IDX_W-1:0]  capIdx;
    logic [DATA_W-1:0] capWdata;
    logic [3:0]        capBe;

    logic [DATA_W-1:0] mem [WORDS];
    logic [DATA_W-1:0] oldWord;
    logic [DATA_W-1:0] mergedWord;
    logic              accessEdge;
    logic              badAccess;
    logic              doWrite;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic capMisaligned;
    logic rspErrQ;

    assign badAccess = capMisaligned;
    assign rsp_err   = rspErrQ;
`else
    assign badAccess = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // Offset bits and bits above the array index never select anything in the default build.
    logic [ADDR_W-IDX_W-1:0] unusedAddrBits;
    assign unusedAddrBits = {req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};

    // NOTE: always_comb gives every output a default first so no latch is inferred.
    always_comb begin
        oldWord    = mem[capIdx];
        mergedWord = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (capBe[i]) begin
                mergedWord[8*i +: 8] = capWdata[8*i +: 8];
            end
        end
    end

    assign accessEdge = (state == WAIT) && (cnt == '0);
    assign doWrite    = accessEdge && capWe && !badAccess;

    // NOTE: the array has no reset so it maps onto RAM and keeps completed stores across a reset.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[capIdx] <= mergedWord;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            capWe     <= 1'b0;
            capIdx    <= '0;
            capWdata  <= '0;
            capBe     <= '0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            capMisaligned <= 1'b0;
            rspErrQ       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        capWe     <= req_we;
                        capIdx    <= req_addr[IDX_W+1:2];
                        capWdata  <= req_wdata;
                        capBe     <= req_be;
`ifdef DATA_MEM_ALIGN_CHECK_EN
                        capMisaligned <= (req_addr[1:0] != 2'b00);
`endif
                        cnt       <= CNT_W'(LATENCY - 1);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // A store reports the word exactly as it lands in the array.
                        if (badAccess) begin
                            rsp_rdata <= '0;
                        end else if (capWe) begin
                            rsp_rdata <= mergedWord;
                        end else begin
                            rsp_rdata <= oldWord;
                        end
`ifdef DATA_MEM_ALIGN_CHECK_EN
                        rspErrQ <= capMisaligned;
`endif
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the TessiaX32 data port. Accepts one load/store request at a time from the CPU memory stage over a valid/ready handshake.
- Performs the access on an internal word array after a fixed, parameterised latency. Returns a held response (read data, error flag) over a second valid/ready handshake.
- Provides a busy indication for the hazard unit to stall the pipeline.

Parameters:
- DATA_W, 32, data word width in bits; must be 32 (byte lanes = DATA_W/8 = 4).
- ADDR_W, 32, request byte-address width.
- WORDS, 256, number of words in the array; power of two, >= 2.
- LATENCY, 2, cycles from the accept edge to rsp_valid; integer >= 1.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data
- req_be  in  4  store byte enables, bit i = byte lane i
- rsp_valid  out  1  response held valid
- rsp_ready  in  1  CPU consumes response
- rsp_rdata  out  DATA_W  load data (store: the merged word as written)
- rsp_err  out  1  access error (see Optional Feature)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; req_ready=0 while asserted, 1 from the first cycle after release.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, latency counter=0.
  - Array contents are not reset.
- Index: idx = req_addr[$clog2(WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo WORDS*4.
- Request fields are captured into registers on accept, so the CPU may change them afterwards.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready (accept edge T0): capture we/idx/wdata/be/addr, load cnt=LATENCY-1, go WAIT.
- WAIT:
  - req_ready=0.
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0 (edge T0+LATENCY):
    - Store: for each lane with be[i]=1, write that byte; rsp_rdata <= the merged word.
    - Load: rsp_rdata <= array[idx].
    - Set rsp_valid=1, go RESP.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On an edge with rsp_ready=1: rsp_valid <= 0, go IDLE. req_ready returns high the following cycle.
  - A request presented during WAIT or RESP is not accepted and stays pending at the CPU.
- Timing:
  - Latency is exactly LATENCY cycles from the accept edge to rsp_valid high.
  - Minimum period between accepts is LATENCY+2 cycles when rsp_ready is held high.
- Stores:
  - be=4'b0000: array unchanged; response still issued, with rsp_rdata = the unchanged word.
  - Read-after-write: a load accepted after a store's response sees the stored bytes.
- Reset mid-operation:
  - An in-flight store that has not reached its write edge is discarded.
  - A store already written stays written.
  - Any pending response is dropped.

Optional Feature:
- Macro: DATA_MEM_ALIGN_CHECK_EN.
- Defined:
  - A request with req_addr[1:0] != 2'b00 performs no array access.
  - At edge T0+LATENCY it returns rsp_err=1, rsp_rdata=0, with the same handshake and latency.
  - Aligned requests return rsp_err=0.
- Undefined:
  - rsp_err is tied 0 and req_addr[1:0] is ignored; the access proceeds on idx.

Test Plan:
- Reset release, LATENCY=2: req_ready=1 on the first cycle after release. Store addr 0x10, wdata 0xDEADBEEF, be=4'hF, rsp_ready=1 -> rsp_valid high after edge T0+2 with rsp_rdata=0xDEADBEEF, one cycle only. Then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte-enable merge: word 0x10 holds 0xDEADBEEF. Store wdata 0x11223344, be=4'b0101 -> rsp_rdata and a subsequent load both return 0xDE22BE44. Store with be=0 -> word unchanged, response still issued.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_rdata stable, req_ready=0, busy=1, and a new req_valid is not accepted. Raise rsp_ready -> rsp_valid drops next cycle, req_ready=1 the cycle after.
- Address wrap, WORDS=256: store 0xA5A5A5A5 to 0x400 -> load 0x000 returns 0xA5A5A5A5.
- Reset mid-operation: assert reset one cycle after accepting a store of 0xCAFEF00D to 0x20 (LATENCY=4) -> all outputs 0 immediately; after release a load of 0x20 returns the old contents.
- With DATA_MEM_ALIGN_CHECK_EN defined: store to 0x22 -> rsp_err=1, rsp_rdata=0, and a load of 0x20 shows no change. Without the macro: the same store writes word 0x20 and rsp_err=0.
